// File: rtl/axi_bram_log_reader_if.sv
// Generic BRAM port bundle: the master drives clock, reset, enable, address and
// write controls; the slave (memory) returns read data one cycle after En_S.
interface BramPort #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                    Clk_C;
    logic                    Rst_R;
    logic                    En_S;
    logic [ADDR_WIDTH-1:0]   Addr_S;
    logic [DATA_WIDTH-1:0]   Rd_D;
    logic [DATA_WIDTH-1:0]   Wr_D;
    logic [DATA_WIDTH/8-1:0] WrEn_S;

    modport Master (
        output Clk_C, Rst_R, En_S, Addr_S, Wr_D, WrEn_S,
        input  Rd_D
    );

    modport Slave (
        input  Clk_C, Rst_R, En_S, Addr_S, Wr_D, WrEn_S,
        output Rd_D
    );
endinterface

// File: rtl/axi_bram_log_reader.sv
// Drains AXI address-log entries from BRAM port B into a decoded, flow-controlled stream.
// Optional build macro AXI_BRAM_LOG_READER_TS_DELTA_EN: emit timestamp deltas instead of absolute values.
module axi_bram_log_reader #(
    parameter int AXI_ADDR_BITW     = 32,
    parameter int AXI_ID_BITW       = 8,
    parameter int AXI_LEN_BITW      = 8,
    parameter int TIMESTAMP_BITW    = 32,
    parameter int LOGGING_DATA_BITW = 96,
    parameter int NUM_SER_BRAMS     = 12,
    localparam int CAP              = 1024 * NUM_SER_BRAMS,
    localparam int CNT_W            = $clog2(CAP) + 1
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RBI,
    input  logic                      Start_SI,
    input  logic                      Abort_SI,
    input  logic [CNT_W-1:0]          NumEntries_DI,
    BramPort.Master                   Bram_PM,
    output logic                      Valid_SO,
    input  logic                      Ready_SI,
    output logic [TIMESTAMP_BITW-1:0] Timestamp_DO,
    output logic [AXI_ADDR_BITW-1:0]  Addr_DO,
    output logic [AXI_ID_BITW-1:0]    Id_DO,
    output logic [AXI_LEN_BITW-1:0]   Len_DO,
    output logic                      Last_SO,
    output logic                      Busy_SO,
    output logic                      Done_SO
);

    localparam int BRAM_ADDR_W = 32;
    localparam int ID_LSB      = 64;
    localparam int LEN_LSB     = ID_LSB + AXI_ID_BITW;
    localparam int FIELD_TOP   = LEN_LSB + AXI_LEN_BITW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]             num_entries;
    logic [CNT_W-1:0]             rd_idx;
    logic [CNT_W-1:0]             num_clamped;
    logic                         rd_vld_p1;
    logic                         rd_last_p1;
    logic [1:0]                   fifo_cnt;
    logic [1:0]                   wr_ptr;
    logic [1:0]                   rd_ptr;
    logic [LOGGING_DATA_BITW-1:0] fifo_data [3];
    logic [2:0]                   fifo_last;
    logic [LOGGING_DATA_BITW-1:0] head;
    logic [TIMESTAMP_BITW-1:0]    head_ts;
    logic [TIMESTAMP_BITW-1:0]    ts_out;
    logic                         fifo_empty;
    logic                         issue;
    logic                         issue_last;
    logic                         push;
    logic                         pop;
    logic                         start_acc;
    logic                         abort_acc;
    logic                         unused_bits;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign num_clamped = (NumEntries_DI > CNT_W'(CAP)) ? CNT_W'(CAP) : NumEntries_DI;
    assign start_acc   = (state == ST_IDLE) && Start_SI;
    assign abort_acc   = ((state == ST_READ) || (state == ST_DRAIN)) && Abort_SI;
    assign fifo_empty  = (fifo_cnt == 2'd0);
    assign push        = rd_vld_p1;
    assign pop         = !fifo_empty && Ready_SI;

    // Issue decision sees only registered occupancy and in-flight counts, so the
    // read side never depends combinationally on the consumer's Ready.
    assign issue      = (state == ST_READ) && !Abort_SI && (rd_idx < num_entries) &&
                        (({1'b0, fifo_cnt} + {2'b00, rd_vld_p1}) < 3'd3);
    assign issue_last = (rd_idx == (num_entries - CNT_W'(1)));

    always_comb begin
        state_nxt = state;
        Busy_SO   = (state != ST_IDLE);
        Done_SO   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start_SI) state_nxt = ST_READ;
            end
            ST_READ: begin
                if (Abort_SI)                     state_nxt = ST_IDLE;
                else if (num_entries == '0)       state_nxt = ST_DONE;
                else if (issue && issue_last)     state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave as soon as the final entry is being handshaken this cycle.
                if (Abort_SI) state_nxt = ST_IDLE;
                else if (!rd_vld_p1 && (fifo_empty || ((fifo_cnt == 2'd1) && pop)))
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                Done_SO   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state       <= ST_IDLE;
            num_entries <= '0;
            rd_idx      <= '0;
            rd_vld_p1   <= 1'b0;
            rd_last_p1  <= 1'b0;
            fifo_cnt    <= 2'd0;
            wr_ptr      <= 2'd0;
            rd_ptr      <= 2'd0;
        end else begin
            state     <= state_nxt;
            rd_vld_p1 <= issue;
            if (issue) begin
                rd_last_p1 <= issue_last;
                rd_idx     <= rd_idx + CNT_W'(1);
            end
            if (start_acc) begin
                num_entries <= num_clamped;
                rd_idx      <= '0;
            end
            // Abort drops buffered entries and the read still in flight.
            if (abort_acc) begin
                fifo_cnt  <= 2'd0;
                wr_ptr    <= 2'd0;
                rd_ptr    <= 2'd0;
                rd_vld_p1 <= 1'b0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                    2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                    default: fifo_cnt <= fifo_cnt;
                endcase
            end
        end
    end

    // BRAM read data lands in the buffer one cycle after the enable
    always_ff @(posedge Clk_CI) begin
        if (push) begin
            fifo_data[wr_ptr] <= Bram_PM.Rd_D;
            fifo_last[wr_ptr] <= rd_last_p1;
        end
    end

    assign head    = fifo_data[rd_ptr];
    assign head_ts = head[TIMESTAMP_BITW-1:0];

`ifdef AXI_BRAM_LOG_READER_TS_DELTA_EN
    logic                      have_prev;
    logic [TIMESTAMP_BITW-1:0] prev_ts;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI)                    have_prev <= 1'b0;
        else if (start_acc || abort_acc) have_prev <= 1'b0;
        else if (pop)                    have_prev <= 1'b1;
    end

    always_ff @(posedge Clk_CI) begin
        if (pop) prev_ts <= head_ts;
    end

    assign ts_out = have_prev ? (head_ts - prev_ts) : head_ts;
`else
    assign ts_out = head_ts;
`endif

    // Data outputs are masked to zero while empty so storage needs no reset.
    assign Valid_SO     = !fifo_empty;
    assign Timestamp_DO = Valid_SO ? ts_out : '0;
    assign Addr_DO      = Valid_SO ? head[32 +: AXI_ADDR_BITW] : '0;
    assign Id_DO        = Valid_SO ? head[ID_LSB +: AXI_ID_BITW] : '0;
    assign Len_DO       = Valid_SO ? head[LEN_LSB +: AXI_LEN_BITW] : '0;
    assign Last_SO      = Valid_SO && fifo_last[rd_ptr];
    assign unused_bits  = ^head[LOGGING_DATA_BITW-1:FIELD_TOP];

    assign Bram_PM.Clk_C  = Clk_CI;
    assign Bram_PM.Rst_R  = ~Rst_RBI;
    assign Bram_PM.En_S   = issue;
    assign Bram_PM.Addr_S = issue ? BRAM_ADDR_W'({rd_idx, 2'b00}) : '0;
    assign Bram_PM.WrEn_S = '0;
    assign Bram_PM.Wr_D   = '0;

endmodule

// File: tb/tb_axi_bram_log_reader.sv
// Directed bench for axi_bram_log_reader with a 1-cycle-latency BRAM model.
module tb_axi_bram_log_reader;
    localparam int CAP   = 1024 * 12;
    localparam int CNT_W = $clog2(CAP) + 1;

    typedef struct {
        logic [31:0] ts;
        logic [31:0] addr;
        logic [7:0]  id;
        logic [7:0]  len;
        logic        last;
        int          c;
    } hs_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num;
    logic             ready;
    logic             valid, last, busy, done;
    logic [31:0]      ts_o, addr_o;
    logic [7:0]       id_o, len_o;

    BramPort #(.DATA_WIDTH(96), .ADDR_WIDTH(32)) bram ();

    logic [95:0] mem [CAP];
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    hs_t  hs_q[$];
    int   done_q[$];
    int   en_cnt, first_busy, first_en, first_vld, stall_err, outstanding, max_out;
    logic [31:0] last_en_addr;
    logic prev_stall;
    logic [31:0] p_ts, p_addr;
    logic [7:0]  p_id, p_len;
    logic        p_last;

    axi_bram_log_reader dut (
        .Clk_CI       (clk),
        .Rst_RBI      (rst_n),
        .Start_SI     (start),
        .Abort_SI     (abort),
        .NumEntries_DI(num),
        .Bram_PM      (bram),
        .Valid_SO     (valid),
        .Ready_SI     (ready),
        .Timestamp_DO (ts_o),
        .Addr_DO      (addr_o),
        .Id_DO        (id_o),
        .Len_DO       (len_o),
        .Last_SO      (last),
        .Busy_SO      (busy),
        .Done_SO      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bram.En_S) bram.Rd_D <= mem[bram.Addr_S[15:2]];

    // Observe on the falling edge, when every input and output is settled
    always @(negedge clk) begin
        hs_t h;
        if (rst_n) begin
            if (valid && ready) begin
                h.ts = ts_o; h.addr = addr_o; h.id = id_o; h.len = len_o; h.last = last; h.c = cyc;
                hs_q.push_back(h);
            end
            if (done) done_q.push_back(cyc);
            if (bram.En_S) begin
                en_cnt++;
                last_en_addr = bram.Addr_S;
                if (first_en < 0) first_en = cyc;
            end
            if (busy && first_busy < 0) first_busy = cyc;
            if (valid && first_vld < 0) first_vld = cyc;
            if (prev_stall && (!valid || ts_o !== p_ts || addr_o !== p_addr ||
                               id_o !== p_id || len_o !== p_len || last !== p_last))
                stall_err++;
            prev_stall = valid && !ready && !abort;
            p_ts = ts_o; p_addr = addr_o; p_id = id_o; p_len = len_o; p_last = last;
            outstanding = outstanding + int'(bram.En_S) - int'(valid && ready);
            if (outstanding > max_out) max_out = outstanding;
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic logic [95:0] make_entry(input logic [31:0] ts, input int i);
        logic [31:0] a;
        logic [7:0]  id;
        a  = 32'h1000 + i;
        id = i[7:0];
        return {16'h0, 8'd7, id, a, ts};
    endfunction

    task automatic load_default();
        for (int i = 0; i < CAP; i++) mem[i] = make_entry(i, i);
        mem[0] = make_entry(32'h10, 0);
        mem[1] = make_entry(32'h11, 1);
        mem[2] = make_entry(32'h15, 2);
        mem[3] = make_entry(32'h20, 3);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        hs_q.delete();
        done_q.delete();
        en_cnt = 0; first_busy = -1; first_en = -1; first_vld = -1;
        stall_err = 0; outstanding = 0; max_out = 0; last_en_addr = '0;
        prev_stall = 1'b0;
    endtask

    task automatic start_drain(input int n, output int t);
        step();
        start = 1'b1;
        num   = CNT_W'(n);
        t     = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        for (int k = 0; k < budget && done_q.size() == 0; k++) begin
            if (toggle) ready = ~ready;
            step();
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0; num = '0;
        clear_mon();
        step(); step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid); end
        checks++; if (last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b expected 0", last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        checks++; if (bram.En_S !== 1'b0) begin errors++; $display("FAIL rst_en: got %b expected 0", bram.En_S); end
        checks++; if (bram.Addr_S !== 32'h0) begin errors++; $display("FAIL rst_addr_s: got %h expected 0", bram.Addr_S); end
        checks++; if (bram.Rst_R !== 1'b1) begin errors++; $display("FAIL rst_rst_r: got %b expected 1", bram.Rst_R); end
        checks++; if (bram.WrEn_S !== '0) begin errors++; $display("FAIL rst_wren: got %h expected 0", bram.WrEn_S); end
        checks++; if ({ts_o, addr_o, id_o, len_o} !== 80'h0) begin
            errors++; $display("FAIL rst_data: got %h expected 0", {ts_o, addr_o, id_o, len_o});
        end
        rst_n = 1'b1;
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_stream();
        int t;
        logic [31:0] exp_ts [4];
`ifdef AXI_BRAM_LOG_READER_TS_DELTA_EN
        exp_ts = '{32'h10, 32'h1, 32'h4, 32'hB};
`else
        exp_ts = '{32'h10, 32'h11, 32'h15, 32'h20};
`endif
        clear_mon();
        ready = 1'b1;
        start_drain(4, t);
        wait_done(40, 1'b0);
        checks++; if (first_busy != t + 1) begin errors++; $display("FAIL stream_busy_cyc: got %0d expected %0d", first_busy, t + 1); end
        checks++; if (first_en != t + 1) begin errors++; $display("FAIL stream_en_cyc: got %0d expected %0d", first_en, t + 1); end
        checks++; if (first_vld != t + 3) begin errors++; $display("FAIL stream_vld_cyc: got %0d expected %0d", first_vld, t + 3); end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL stream_done_cnt: got %0d expected 1", done_q.size()); end
        else begin
            checks++; if (done_q[0] != t + 7) begin errors++; $display("FAIL stream_done_cyc: got %0d expected %0d", done_q[0], t + 7); end
        end
        checks++; if (hs_q.size() != 4) begin errors++; $display("FAIL stream_count: got %0d expected 4", hs_q.size()); end
        for (int i = 0; i < hs_q.size() && i < 4; i++) begin
            checks++; if (hs_q[i].c != t + 3 + i) begin errors++; $display("FAIL stream_cyc[%0d]: got %0d expected %0d", i, hs_q[i].c, t + 3 + i); end
            checks++; if (hs_q[i].ts !== exp_ts[i]) begin errors++; $display("FAIL stream_ts[%0d]: got %h expected %h", i, hs_q[i].ts, exp_ts[i]); end
            checks++; if (hs_q[i].addr !== 32'h1000 + i) begin errors++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, hs_q[i].addr, 32'h1000 + i); end
            checks++; if (hs_q[i].id !== 8'(i)) begin errors++; $display("FAIL stream_id[%0d]: got %h expected %h", i, hs_q[i].id, 8'(i)); end
            checks++; if (hs_q[i].len !== 8'd7) begin errors++; $display("FAIL stream_len[%0d]: got %h expected 07", i, hs_q[i].len); end
            checks++; if (hs_q[i].last !== (i == 3)) begin errors++; $display("FAIL stream_last[%0d]: got %b expected %b", i, hs_q[i].last, i == 3); end
        end
    endtask

    task automatic test_backpressure();
        int t;
        logic [31:0] exp_ts [4];
`ifdef AXI_BRAM_LOG_READER_TS_DELTA_EN
        exp_ts = '{32'h10, 32'h1, 32'h4, 32'hB};
`else
        exp_ts = '{32'h10, 32'h11, 32'h15, 32'h20};
`endif
        clear_mon();
        ready = 1'b1;
        start_drain(4, t);
        wait_done(60, 1'b1);
        ready = 1'b0;
        checks++; if (hs_q.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", hs_q.size()); end
        for (int i = 0; i < hs_q.size() && i < 4; i++) begin
            checks++; if (hs_q[i].addr !== 32'h1000 + i) begin errors++; $display("FAIL bp_addr[%0d]: got %h expected %h", i, hs_q[i].addr, 32'h1000 + i); end
            checks++; if (hs_q[i].ts !== exp_ts[i]) begin errors++; $display("FAIL bp_ts[%0d]: got %h expected %h", i, hs_q[i].ts, exp_ts[i]); end
            checks++; if (hs_q[i].last !== (i == 3)) begin errors++; $display("FAIL bp_last[%0d]: got %b expected %b", i, hs_q[i].last, i == 3); end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_err); end
        checks++; if (max_out > 3) begin errors++; $display("FAIL bp_outstanding: got %0d expected <= 3", max_out); end
        checks++; if (en_cnt != 4) begin errors++; $display("FAIL bp_reads: got %0d expected 4", en_cnt); end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL bp_done_cnt: got %0d expected 1", done_q.size()); end
    endtask

    task automatic test_zero();
        int t;
        clear_mon();
        ready = 1'b1;
        start_drain(0, t);
        wait_done(20, 1'b0);
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL zero_done_cnt: got %0d expected 1", done_q.size()); end
        else begin
            checks++; if (done_q[0] != t + 2) begin errors++; $display("FAIL zero_done_cyc: got %0d expected %0d", done_q[0], t + 2); end
        end
        checks++; if (en_cnt != 0) begin errors++; $display("FAIL zero_reads: got %0d expected 0", en_cnt); end
        checks++; if (first_vld != -1) begin errors++; $display("FAIL zero_valid: got cycle %0d expected none", first_vld); end
    endtask

    task automatic test_abort();
        int t;
        logic [31:0] exp_ts [2];
`ifdef AXI_BRAM_LOG_READER_TS_DELTA_EN
        exp_ts = '{32'h10, 32'h1};
`else
        exp_ts = '{32'h10, 32'h11};
`endif
        clear_mon();
        ready = 1'b0;
        start_drain(4, t);
        while (cyc < t + 5) step();
        checks++; if (first_vld != t + 3) begin errors++; $display("FAIL abort_vld_cyc: got %0d expected %0d", first_vld, t + 3); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        repeat (5) step();
        checks++; if (done_q.size() != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_q.size()); end
        checks++; if (hs_q.size() != 0) begin errors++; $display("FAIL abort_no_hs: got %0d expected 0", hs_q.size()); end
        clear_mon();
        ready = 1'b1;
        start_drain(2, t);
        wait_done(30, 1'b0);
        checks++; if (hs_q.size() != 2) begin errors++; $display("FAIL restart_count: got %0d expected 2", hs_q.size()); end
        for (int i = 0; i < hs_q.size() && i < 2; i++) begin
            checks++; if (hs_q[i].addr !== 32'h1000 + i) begin errors++; $display("FAIL restart_addr[%0d]: got %h expected %h", i, hs_q[i].addr, 32'h1000 + i); end
            checks++; if (hs_q[i].ts !== exp_ts[i]) begin errors++; $display("FAIL restart_ts[%0d]: got %h expected %h", i, hs_q[i].ts, exp_ts[i]); end
            checks++; if (hs_q[i].last !== (i == 1)) begin errors++; $display("FAIL restart_last[%0d]: got %b expected %b", i, hs_q[i].last, i == 1); end
        end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL restart_done_cnt: got %0d expected 1", done_q.size()); end
        else begin
            checks++; if (done_q[0] != t + 5) begin errors++; $display("FAIL restart_done_cyc: got %0d expected %0d", done_q[0], t + 5); end
        end
    endtask

    task automatic test_wrap();
        int t;
        logic [31:0] exp_ts [2];
`ifdef AXI_BRAM_LOG_READER_TS_DELTA_EN
        exp_ts = '{32'hFFFF_FFFE, 32'h3};
`else
        exp_ts = '{32'hFFFF_FFFE, 32'h1};
`endif
        mem[0] = make_entry(32'hFFFF_FFFE, 0);
        mem[1] = make_entry(32'h1, 1);
        clear_mon();
        ready = 1'b1;
        start_drain(2, t);
        wait_done(30, 1'b0);
        checks++; if (hs_q.size() != 2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", hs_q.size()); end
        for (int i = 0; i < hs_q.size() && i < 2; i++) begin
            checks++; if (hs_q[i].ts !== exp_ts[i]) begin errors++; $display("FAIL wrap_ts[%0d]: got %h expected %h", i, hs_q[i].ts, exp_ts[i]); end
        end
        load_default();
    endtask

    task automatic test_reset_mid();
        int t;
        clear_mon();
        ready = 1'b0;
        start_drain(4, t);
        step(); step();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b expected 1", valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (bram.En_S !== 1'b0) begin errors++; $display("FAIL rmid_en: got %b expected 0", bram.En_S); end
        checks++; if (bram.Addr_S !== 32'h0) begin errors++; $display("FAIL rmid_addr_s: got %h expected 0", bram.Addr_S); end
        checks++; if ({ts_o, addr_o, id_o, len_o, last, done} !== 82'h0) begin
            errors++; $display("FAIL rmid_outputs: got %h expected 0", {ts_o, addr_o, id_o, len_o, last, done});
        end
        step(); step();
        rst_n = 1'b1;
        step();
        clear_mon();
        ready = 1'b1;
        start_drain(2, t);
        wait_done(30, 1'b0);
        checks++; if (hs_q.size() != 2) begin errors++; $display("FAIL rmid_count: got %0d expected 2", hs_q.size()); end
        for (int i = 0; i < hs_q.size() && i < 2; i++) begin
            checks++; if (hs_q[i].id !== 8'(i)) begin errors++; $display("FAIL rmid_id[%0d]: got %h expected %h", i, hs_q[i].id, 8'(i)); end
        end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL rmid_done_cnt: got %0d expected 1", done_q.size()); end
        else begin
            checks++; if (done_q[0] != t + 5) begin errors++; $display("FAIL rmid_done_cyc: got %0d expected %0d", done_q[0], t + 5); end
        end
    endtask

    task automatic test_cap();
        int t;
        int lasts;
        clear_mon();
        ready = 1'b1;
        start_drain(CAP + 5, t);
        wait_done(CAP + 100, 1'b0);
        lasts = 0;
        foreach (hs_q[i]) if (hs_q[i].last) lasts++;
        checks++; if (hs_q.size() != CAP) begin errors++; $display("FAIL cap_count: got %0d expected %0d", hs_q.size(), CAP); end
        checks++; if (en_cnt != CAP) begin errors++; $display("FAIL cap_reads: got %0d expected %0d", en_cnt, CAP); end
        checks++; if (last_en_addr !== 32'((CAP - 1) << 2)) begin
            errors++; $display("FAIL cap_last_addr_s: got %h expected %h", last_en_addr, 32'((CAP - 1) << 2));
        end
        checks++; if (lasts != 1) begin errors++; $display("FAIL cap_last_flags: got %0d expected 1", lasts); end
        if (hs_q.size() > 0) begin
            checks++; if (hs_q[hs_q.size()-1].addr !== 32'h1000 + CAP - 1) begin
                errors++; $display("FAIL cap_last_entry: got %h expected %h", hs_q[hs_q.size()-1].addr, 32'h1000 + CAP - 1);
            end
        end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL cap_done_cnt: got %0d expected 1", done_q.size()); end
        else begin
            checks++; if (done_q[0] != t + CAP + 3) begin errors++; $display("FAIL cap_done_cyc: got %0d expected %0d", done_q[0], t + CAP + 3); end
        end
    endtask

    initial begin
        load_default();
        test_reset();
        test_stream();
        test_backpressure();
        test_zero();
        test_abort();
        test_wrap();
        test_reset_mid();
        test_cap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
